reg_file: RTL and testbench

Architectural register file that consumes the writeback value produced by the writeback selector. It provides one synchronous write port and two combinational read ports, with register 0 hardwired to zero. After reset, an internal state machine sweeps every entry to zero, one entry per cycle, so the storage can infer as plain RAM with no per-entry reset. A `ready` output tells the control path when the file may be used.

---
 rtl/reg_file.sv | 166 ++++++++++++++++
 tb/tb_reg_file.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file: architectural register file fed by the writeback selector.
//
// One synchronous write port and two combinational read ports. Register 0
// always reads as zero and ignores writes. After reset an internal sweep
// clears one entry per cycle, so the storage array carries no per-entry reset
// and can map onto plain RAM. `ready` rises once the sweep has finished.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   synchronous reset, active low
//   we      in   write enable from control
//   waddr   in   [ADDR_WIDTH] destination register index
//   wdata   in   [DATA_WIDTH] writeback data
//   raddr1  in   [ADDR_WIDTH] source register 1 index
//   raddr2  in   [ADDR_WIDTH] source register 2 index
//   rdata1  out  [DATA_WIDTH] source register 1 value
//   rdata2  out  [DATA_WIDTH] source register 2 value
//   ready   out  high once the clear sweep is complete
//
// Optional feature macro: REG_FILE_WRITE_BYPASS_EN
//   When defined, a read of the register being written in the same cycle
//   returns wdata (write-through). When undefined, the pre-write value is
//   returned and the new value appears from the next cycle.
// -----------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic                  ready
);

    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE_IDX   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = {ADDR_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [ADDR_WIDTH-1:0] cnt_r;
    logic [ADDR_WIDTH-1:0] cnt_s;
    logic                  ready_r;
    logic                  ready_s;

    // Single storage write port shared by the clear sweep and external writes.
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [DATA_WIDTH-1:0] mem_data_s;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic [DATA_WIDTH-1:0] rdata1_s;
    logic [DATA_WIDTH-1:0] rdata2_s;

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_INIT;
            cnt_r   <= ZERO_IDX;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ready_r <= ready_s;
        end
    end

    // Next-state logic and selection of the storage write source.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        ready_s    = ready_r;
        mem_we_s   = 1'b0;
        mem_addr_s = ZERO_IDX;
        mem_data_s = ZERO_DATA;
        case (state_r)
            ST_INIT: begin
                // External writes are ignored until every entry is cleared.
                mem_we_s   = 1'b1;
                mem_addr_s = cnt_r;
                mem_data_s = ZERO_DATA;
                cnt_s      = cnt_r + ONE_IDX;
                if (cnt_r == LAST_IDX) begin
                    state_s = ST_RUN;
                    ready_s = 1'b1;
                end else begin
                    state_s = ST_INIT;
                    ready_s = 1'b0;
                end
            end
            ST_RUN: begin
                ready_s = 1'b1;
                if (we && (waddr != ZERO_IDX)) begin
                    mem_we_s   = 1'b1;
                    mem_addr_s = waddr;
                    mem_data_s = wdata;
                end else begin
                    mem_we_s   = 1'b0;
                end
            end
            default: begin
                state_s = ST_INIT;
                cnt_s   = ZERO_IDX;
                ready_s = 1'b0;
            end
        endcase
    end

    // Storage array: no reset so it can map onto RAM; reset blocks any write.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_s) begin
            mem_r[mem_addr_s] <= mem_data_s;
        end
    end

    // Read port 1: zero during the sweep and for index 0.
    always_comb begin
        rdata1_s = ZERO_DATA;
        if (state_r != ST_RUN) begin
            rdata1_s = ZERO_DATA;
        end else if (raddr1 == ZERO_IDX) begin
            rdata1_s = ZERO_DATA;
`ifdef REG_FILE_WRITE_BYPASS_EN
        end else if (we && (waddr == raddr1)) begin
            rdata1_s = wdata;
`endif
        end else begin
            rdata1_s = mem_r[raddr1];
        end
    end

    // Read port 2: same rules as port 1, bypassed independently.
    always_comb begin
        rdata2_s = ZERO_DATA;
        if (state_r != ST_RUN) begin
            rdata2_s = ZERO_DATA;
        end else if (raddr2 == ZERO_IDX) begin
            rdata2_s = ZERO_DATA;
`ifdef REG_FILE_WRITE_BYPASS_EN
        end else if (we && (waddr == raddr2)) begin
            rdata2_s = wdata;
`endif
        end else begin
            rdata2_s = mem_r[raddr2];
        end
    end

    assign rdata1 = rdata1_s;
    assign rdata2 = rdata2_s;
    assign ready  = ready_r;

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file: directed self-checking bench for reg_file (default parameters).
// Inputs change just after the falling edge; outputs are sampled 1ns later or
// on the following falling edge, away from the rising edge.
// -----------------------------------------------------------------------------
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        ready;

    int total;
    int bad;

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .ready  (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then return to the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] fill_val(input int i);
        return 32'hA500_0000 + i * 32'h0001_0101;
    endfunction

    // Reset for two edges, then sweep while hammering a write to r5.
    task automatic test_reset();
        rst_n = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
        raddr1 = 5'd3; raddr2 = 5'd4;
        tick();
        tick();
        total++;
        if (ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready actual=%0b required=0", ready);
        end
        total++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
            bad++; $display("FAIL reset_rdata actual=%h/%h required=0/0", rdata1, rdata2);
        end
        rst_n = 1'b1;
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        for (int i = 1; i <= 32; i++) begin
            raddr1 = 5'(i - 1);
            raddr2 = 5'(32 - i);
            #1;
            total++;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
                bad++;
                $display("FAIL sweep_rdata edge=%0d actual=%h/%h required=0/0", i, rdata1, rdata2);
            end
            tick();
            total++;
            if (ready !== (i == 32)) begin
                bad++;
                $display("FAIL sweep_ready edge=%0d actual=%0b required=%0b", i, ready, (i == 32));
            end
        end
        we = 1'b0;
    endtask

    // The write attempted during the sweep must not have landed.
    task automatic test_init_write();
        raddr1 = 5'd5; raddr2 = 5'd6;
        #1;
        total++;
        if (rdata1 !== 32'h0) begin
            bad++; $display("FAIL init_write actual=%h required=00000000", rdata1);
        end
        total++;
        if (rdata2 !== 32'h0) begin
            bad++; $display("FAIL cleared_r6 actual=%h required=00000000", rdata2);
        end
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
        tick();
        we = 1'b0; raddr1 = 5'd7; raddr2 = 5'd7;
        #1;
        total++;
        if (rdata1 !== 32'h12345678 || rdata2 !== 32'h12345678) begin
            bad++; $display("FAIL wr_r7 actual=%h/%h required=12345678/12345678", rdata1, rdata2);
        end
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0; raddr2 = 5'd7;
        #1;
        total++;
        if (rdata1 !== 32'h0) begin
            bad++; $display("FAIL wr_r0_same actual=%h required=00000000", rdata1);
        end
        tick();
        we = 1'b0;
        #1;
        total++;
        if (rdata1 !== 32'h0) begin
            bad++; $display("FAIL wr_r0 actual=%h required=00000000", rdata1);
        end
        total++;
        if (rdata2 !== 32'h12345678) begin
            bad++; $display("FAIL r7_kept actual=%h required=12345678", rdata2);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp1;
        we = 1'b1; waddr = 5'd9; wdata = 32'hA;
        tick();
        we = 1'b1; waddr = 5'd9; wdata = 32'hB; raddr1 = 5'd9; raddr2 = 5'd8;
`ifdef REG_FILE_WRITE_BYPASS_EN
        exp1 = 32'hB;
`else
        exp1 = 32'hA;
`endif
        #1;
        total++;
        if (rdata1 !== exp1) begin
            bad++; $display("FAIL same_cycle actual=%h required=%h", rdata1, exp1);
        end
        total++;
        if (rdata2 !== 32'h0) begin
            bad++; $display("FAIL other_port actual=%h required=00000000", rdata2);
        end
        tick();
        we = 1'b0;
        #1;
        total++;
        if (rdata1 !== 32'hB) begin
            bad++; $display("FAIL next_cycle actual=%h required=0000000b", rdata1);
        end
    endtask

    // Fill r1..r31 on consecutive cycles, then read back on both ports.
    task automatic test_back_to_back();
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = fill_val(i);
            tick();
        end
        we = 1'b0;
        for (int i = 1; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(32 - i);
            #1;
            total++;
            if (rdata1 !== fill_val(i) || rdata2 !== fill_val(32 - i)) begin
                bad++;
                $display("FAIL b2b_read idx=%0d actual=%h/%h required=%h/%h",
                         i, rdata1, rdata2, fill_val(i), fill_val(32 - i));
            end
            tick();
        end
    endtask

    // Reset during RUN, then again at cnt=10: the sweep must restart from 0.
    task automatic test_mid_reset();
        raddr1 = 5'd7; raddr2 = 5'd31;
        rst_n = 1'b0;
        tick();
        total++;
        if (ready !== 1'b0 || rdata1 !== 32'h0) begin
            bad++; $display("FAIL midrst_run actual=%0b/%h required=0/00000000", ready, rdata1);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            total++;
            if (ready !== (i == 32)) begin
                bad++;
                $display("FAIL resweep_ready edge=%0d actual=%0b required=%0b", i, ready, (i == 32));
            end
        end
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            total++;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
                bad++;
                $display("FAIL resweep_clear idx=%0d actual=%h/%h required=0/0", i, rdata1, rdata2);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
        raddr1 = 5'd0; raddr2 = 5'd0;
        @(negedge clk);
        test_reset();
        test_init_write();
        test_write_read();
        test_same_cycle();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
